sw_reg_responder: RTL and testbench
===================================

# sw_reg_responder

Switch-side endpoint of the decoder-to-switch register bus. One instance sits in each switch and answers the `sel_en`/`addr`/`wr_data`/`wr_rd_s` requests that the address decoder drives. It holds the switch's four port registers and completes every accepted request with a single-cycle `ack`, after a programmable latency. Reads return `rd_data` in that same `ack` cycle. It also exports a `busy` flag that the decoder's scheduler uses as `sw_busy`.

## Interface
- `W_WIDTH`, 8: register and data width.
- `READ_DELAY`, 1: wait cycles inserted before a read `ack`; 0..15.
- `WRITE_DELAY`, 0: wait cycles inserted before a write `ack`; 0..15.
- `RESET_VAL`, 0: reset value of all four registers.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sel_en`  in  1  request strobe for this switch; single-cycle pulse.
- `addr`  in  2  register index 0..3; qualified by `sel_en`.
- `wr_data`  in  W_WIDTH  write data; qualified by `sel_en`.
- `wr_rd_s`  in  1  1 = write, 0 = read; qualified by `sel_en`.
- `ack`  out  1  one-cycle completion pulse.
- `rd_data`  out  W_WIDTH  read data; valid only when `ack` is high and the request was a read; 0 otherwise.
- `busy`  out  1  high from the cycle after acceptance through the `ack` cycle.
- `err_collision`  out  1  one-cycle pulse when `sel_en` arrives while not in IDLE.
- `reg_q`  out  4*W_WIDTH  register contents; register k is at `[k*W_WIDTH +: W_WIDTH]`.

## Operation
- FSM has three states: IDLE, WAIT, ACK.
- IDLE:
  - When `sel_en`=1, capture `addr`, `wr_data` and `wr_rd_s`.
  - Load the counter with READ_DELAY or WRITE_DELAY, chosen by `wr_rd_s`.
  - If the selected delay is 0, go to ACK; otherwise go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 1, go to ACK.
- Commit, on the edge entering ACK:
  - Write: register[addr] <= captured data.
  - Read: `rd_data` <= register[addr].
- ACK: assert `ack` for one cycle, then return to IDLE.
- `sel_en` seen in WAIT or ACK is dropped: `err_collision` pulses in the next cycle and no state changes. The decoder must wait for `ack` before re-selecting this switch.
- `sel_en` is never accepted in the ACK cycle. The earliest next acceptance is the cycle after `ack`.
- A read of a register returns the value committed by any earlier acked write.
- `addr` uses all 2 bits; every value is legal and there is no decode error.
- `wr_data` and `addr` are ignored when `sel_en`=0.

## Timing
- Request sampled at edge T:
  - `ack` is high during cycle T+1+D, where D is the applicable delay.
  - `busy` is high during cycles T+1 .. T+1+D.
- Write: `reg_q` shows the new value in the `ack` cycle and afterwards.
- Reset (`rst`=1 sampled at an edge), effective next cycle:
  - state = IDLE, counter = 0.
  - `ack` = 0, `busy` = 0, `err_collision` = 0, `rd_data` = 0.
  - all four registers = RESET_VAL.
- Reset mid-operation aborts the request: no `ack` is issued and no pending write is committed. A `sel_en` in the same cycle as `rst` is ignored.
- All outputs come directly from flops; there are no combinational input-to-output paths.

## Structure
- Shared package (`sw_reg_pkg`):
  - state enum IDLE/WAIT/ACK.
  - `SW_ADDR_W` = 2.
  - `SW_NUM_REGS` = 4.
  - `OP_WRITE` = 1'b1, `OP_READ` = 1'b0.
- Sub-module `sw_reg_file`:
  - 4×W_WIDTH flops with synchronous write port and registered read port.
  - Resets to RESET_VAL.
  - Exposes the flat `reg_q`.
- The FSM, counter and capture registers live in the top.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with RESET_VAL=8'h3C -> `reg_q`=32'h3C3C3C3C; `ack`, `busy`, `rd_data`, `err_collision` all 0.
- Write, WRITE_DELAY=0: `sel_en` with `addr`=2, `wr_data`=8'hA5, `wr_rd_s`=1 at edge T -> `ack` at T+1, `reg_q[23:16]`=8'hA5, `rd_data`=0, `busy` high only at T+1.
- Read, READ_DELAY=3: after the write above, read `addr`=2 at T -> `busy` high T+1..T+4; `ack` and `rd_data`=8'hA5 at T+4 only; `rd_data`=0 at T+5.
- Collision, READ_DELAY=3: read accepted at T, second `sel_en` at T+2 (write `addr`=0, 8'hFF) -> `err_collision` at T+3; register 0 unchanged; exactly one `ack` at T+4.
- Reset mid-operation: write `addr`=1, 8'h77 with WRITE_DELAY=4 at T; `rst` at T+2 -> no `ack` at any later cycle; register 1 = RESET_VAL; a new read at `addr`=1 returns RESET_VAL.
- Back-to-back sweep: write 8'h10, 8'h21, 8'h32, 8'h43 to `addr` 0..3, each issued the cycle after the previous `ack`; then read all four -> 4 write acks, then reads return 8'h10, 8'h21, 8'h32, 8'h43; `err_collision` never asserts.

Source files
------------

// File: rtl/sw_reg_pkg.sv
// Shared types and constants for the switch-side register bus responder.
package sw_reg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } sw_state_e;

    localparam int unsigned SW_ADDR_W   = 2;
    localparam int unsigned SW_NUM_REGS = 4;
    localparam int unsigned SW_CNT_W    = 4;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

endpackage

// File: rtl/sw_reg_responder_if.sv
// Decoder-to-switch register bus: request strobe/fields one way, completion the other.
interface sw_reg_responder_if #(
    parameter int unsigned W_WIDTH = 8
);
    import sw_reg_pkg::*;

    logic                 sel_en;
    logic [SW_ADDR_W-1:0] addr;
    logic [W_WIDTH-1:0]   wr_data;
    logic                 wr_rd_s;
    logic                 ack;
    logic [W_WIDTH-1:0]   rd_data;
    logic                 busy;
    logic                 err_collision;

    modport master (
        output sel_en, addr, wr_data, wr_rd_s,
        input  ack, rd_data, busy, err_collision
    );

    modport slave (
        input  sel_en, addr, wr_data, wr_rd_s,
        output ack, rd_data, busy, err_collision
    );

endinterface

// File: rtl/sw_reg_file.sv
// Four switch port registers with a synchronous write port and a registered read port.
module sw_reg_file
    import sw_reg_pkg::*;
#(
    parameter int unsigned        W_WIDTH   = 8,
    parameter logic [W_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            we_i,
    input  logic                            re_i,
    input  logic [SW_ADDR_W-1:0]            addr_i,
    input  logic [W_WIDTH-1:0]              wdata_i,
    output logic [W_WIDTH-1:0]              rdata_o,
    output logic [SW_NUM_REGS*W_WIDTH-1:0]  reg_q_o
);

    logic [W_WIDTH-1:0] regs_q [SW_NUM_REGS];
    logic [W_WIDTH-1:0] rdata_q;

    // Read data is only non-zero in the cycle following a read enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SW_NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                regs_q[addr_i] <= wdata_i;
            end
            rdata_q <= re_i ? regs_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

    for (genvar k = 0; k < SW_NUM_REGS; k++) begin : g_flat
        assign reg_q_o[k*W_WIDTH +: W_WIDTH] = regs_q[k];
    end

endmodule

// File: rtl/sw_reg_responder.sv
// Switch-side register bus endpoint: accepts one request at a time and acks it
// after a per-direction programmable latency.
module sw_reg_responder
    import sw_reg_pkg::*;
#(
    parameter int unsigned        W_WIDTH     = 8,
    parameter int unsigned        READ_DELAY  = 1,
    parameter int unsigned        WRITE_DELAY = 0,
    parameter logic [W_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    sw_reg_responder_if.slave              bus_if,
    output logic [SW_NUM_REGS*W_WIDTH-1:0] reg_q_o
);

    localparam logic [SW_CNT_W-1:0] RdDly = SW_CNT_W'(READ_DELAY);
    localparam logic [SW_CNT_W-1:0] WrDly = SW_CNT_W'(WRITE_DELAY);

    sw_state_e            state_q, state_d;
    logic [SW_CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW_ADDR_W-1:0] addr_q, addr_d;
    logic [W_WIDTH-1:0]   data_q, data_d;
    logic                 op_q, op_d;
    logic                 ack_q, busy_q, err_q;
    logic                 commit, we, re;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (bus_if.sel_en) begin
                    addr_d  = bus_if.addr;
                    data_d  = bus_if.wr_data;
                    op_d    = bus_if.wr_rd_s;
                    cnt_d   = (bus_if.wr_rd_s == OP_WRITE) ? WrDly : RdDly;
                    state_d = (cnt_d == '0) ? StAck : StWait;
                end
            end
            StWait: begin
                if (cnt_q <= SW_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - SW_CNT_W'(1);
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The _d capture values are valid on the entering edge, including the zero-delay path.
    assign commit = (state_d == StAck) && (state_q != StAck);
    assign we     = commit && (op_d == OP_WRITE);
    assign re     = commit && (op_d == OP_READ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= OP_READ;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            ack_q   <= (state_d == StAck);
            busy_q  <= (state_d != StIdle);
            err_q   <= bus_if.sel_en && (state_q != StIdle);
        end
    end

    sw_reg_file #(
        .W_WIDTH   (W_WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_reg_file (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .re_i    (re),
        .addr_i  (addr_d),
        .wdata_i (data_d),
        .rdata_o (bus_if.rd_data),
        .reg_q_o (reg_q_o)
    );

    assign bus_if.ack           = ack_q;
    assign bus_if.busy          = busy_q;
    assign bus_if.err_collision = err_q;

endmodule

// File: tb/tb_sw_reg_responder.sv
// Scoreboard bench for sw_reg_responder: directed requests push expectations,
// a negedge monitor checks ack timing, read data, busy, collisions and registers.
module tb_sw_reg_responder;
    import sw_reg_pkg::*;

    localparam int unsigned W  = 8;
    localparam logic [7:0]  RV = 8'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [31:0] reg_q_a, reg_q_b;

    sw_reg_responder_if #(.W_WIDTH(W)) bus_a ();
    sw_reg_responder_if #(.W_WIDTH(W)) bus_b ();

    sw_reg_responder #(
        .W_WIDTH(W), .READ_DELAY(3), .WRITE_DELAY(0), .RESET_VAL(RV)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .bus_if(bus_a), .reg_q_o(reg_q_a)
    );

    sw_reg_responder #(
        .W_WIDTH(W), .READ_DELAY(3), .WRITE_DELAY(4), .RESET_VAL(RV)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .bus_if(bus_b), .reg_q_o(reg_q_b)
    );

    typedef struct {
        int         start_cyc;
        int         ack_cyc;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
    } txn_t;

    txn_t       sbq[$];
    int         errq[$];
    logic [7:0] model[4];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         b_ack_cnt = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor for dut_a: pops the scoreboard whenever ack is presented.
    always @(negedge clk) begin : mon
        txn_t t;
        logic busy_exp, err_exp;
        if (mon_en) begin
            busy_exp = (sbq.size() > 0) && (cyc >= sbq[0].start_cyc);
            check("busy", 32'(bus_a.busy), 32'(busy_exp));
            err_exp = (errq.size() > 0) && (errq[0] == cyc);
            if (err_exp) void'(errq.pop_front());
            check("err_collision", 32'(bus_a.err_collision), 32'(err_exp));
            if (bus_a.ack === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", 32'(bus_a.ack), 32'd0);
                end else begin
                    t = sbq.pop_front();
                    check("ack_cycle", cyc, t.ack_cyc);
                    if (t.wr) begin
                        model[t.addr] = t.data;
                        check("wr_ack_rd_data", 32'(bus_a.rd_data), 32'd0);
                        check("reg_q", reg_q_a, {model[3], model[2], model[1], model[0]});
                    end else begin
                        check("rd_data", 32'(bus_a.rd_data), 32'(t.exp_rd));
                    end
                end
            end else begin
                check("rd_data_idle", 32'(bus_a.rd_data), 32'd0);
            end
        end
    end

    always @(negedge clk) if (bus_b.ack === 1'b1) b_ack_cnt++;

    // Called at a negedge; drives a one-cycle request and records its expectation.
    task automatic issue(input logic wr, input logic [1:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input int dly);
        txn_t t;
        bus_a.sel_en  = 1'b1;
        bus_a.addr    = a;
        bus_a.wr_data = d;
        bus_a.wr_rd_s = wr;
        t.start_cyc = cyc + 1;
        t.ack_cyc   = cyc + 1 + dly;
        t.wr        = wr;
        t.addr      = a;
        t.data      = d;
        t.exp_rd    = exp_rd;
        sbq.push_back(t);
        @(negedge clk);
        bus_a.sel_en  = 1'b0;
        bus_a.wr_data = '0;
    endtask

    // Returns at the negedge of the cycle after ack, the earliest legal re-issue point.
    task automatic wait_ack(input string name);
        int n = 0;
        while (bus_a.ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check({name, "_timeout"}, 32'(bus_a.ack), 32'd1);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sweep[4];
        int n;
        sweep = '{8'h10, 8'h21, 8'h32, 8'h43};
        for (int i = 0; i < 4; i++) model[i] = RV;

        bus_a.sel_en = 0; bus_a.addr = 0; bus_a.wr_data = 0; bus_a.wr_rd_s = 0;
        bus_b.sel_en = 0; bus_b.addr = 0; bus_b.wr_data = 0; bus_b.wr_rd_s = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        check("rst_reg_q", reg_q_a, 32'h3C3C3C3C);
        check("rst_ack", 32'(bus_a.ack), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_rd_data", 32'(bus_a.rd_data), 32'd0);
        check("rst_err", 32'(bus_a.err_collision), 32'd0);
        mon_en = 1'b1;

        issue(OP_WRITE, 2'd2, 8'hA5, 8'h00, 0);
        wait_ack("write_a5");
        issue(OP_READ, 2'd2, 8'h00, 8'hA5, 3);
        wait_ack("read_a5");

        // Collision: second strobe two edges after acceptance while in WAIT.
        issue(OP_READ, 2'd0, 8'h00, RV, 3);
        @(negedge clk);
        bus_a.sel_en = 1'b1; bus_a.addr = 2'd0; bus_a.wr_data = 8'hFF; bus_a.wr_rd_s = OP_WRITE;
        errq.push_back(cyc + 1);
        @(negedge clk);
        bus_a.sel_en = 1'b0; bus_a.wr_data = '0;
        wait_ack("collision_read");
        check("collision_reg0", 32'(reg_q_a[7:0]), 32'(RV));

        for (int i = 0; i < 4; i++) begin
            issue(OP_WRITE, 2'(i), sweep[i], 8'h00, 0);
            wait_ack("sweep_write");
        end
        for (int i = 0; i < 4; i++) begin
            issue(OP_READ, 2'(i), 8'h00, sweep[i], 3);
            wait_ack("sweep_read");
        end
        check("sweep_reg_q", reg_q_a, 32'h43322110);
        check("sb_empty", sbq.size(), 0);

        // Reset mid-operation on the WRITE_DELAY=4 instance.
        @(negedge clk);
        b_ack_cnt = 0;
        bus_b.sel_en = 1'b1; bus_b.addr = 2'd1; bus_b.wr_data = 8'h77; bus_b.wr_rd_s = OP_WRITE;
        @(negedge clk);
        bus_b.sel_en = 1'b0; bus_b.wr_data = '0;
        @(negedge clk);
        check("b_busy_wait", 32'(bus_b.busy), 32'd1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (8) @(negedge clk);
        check("b_abort_no_ack", b_ack_cnt, 0);
        check("b_abort_busy", 32'(bus_b.busy), 32'd0);
        check("b_abort_reg1", 32'(reg_q_b[15:8]), 32'(RV));

        // Strobe coincident with reset must be ignored.
        bus_b.sel_en = 1'b1; bus_b.wr_rd_s = OP_READ; bus_b.addr = 2'd3;
        rst_b = 1'b1;
        @(negedge clk);
        bus_b.sel_en = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("b_rst_sel_busy", 32'(bus_b.busy), 32'd0);
        repeat (5) @(negedge clk);
        check("b_rst_sel_no_ack", b_ack_cnt, 0);

        bus_b.sel_en = 1'b1; bus_b.addr = 2'd1; bus_b.wr_rd_s = OP_READ;
        @(negedge clk);
        bus_b.sel_en = 1'b0;
        n = 0;
        while (bus_b.ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_read_ack_seen", 32'(bus_b.ack), 32'd1);
        check("b_read_latency", n, 3);
        check("b_read_rd_data", 32'(bus_b.rd_data), 32'(RV));
        repeat (3) @(negedge clk);
        check("b_ack_count", b_ack_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
